cva6_wt_mem_responder: RTL and testbench

CVA6_WT_MEM_RESPONDER -- requirements
Module: cva6_wt_mem_responder

---
 rtl/cva6_wt_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_cva6_wt_mem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_wt_mem_responder.sv
// Single-port SRAM model behind a valid/ready request port. Each request is
// serialised through IDLE -> ACCESS -> PUSH and answered in order from a small response FIFO.
module cva6_wt_mem_responder #(
    parameter int unsigned MemTidWidth = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned LineWidth   = 128,
    parameter int unsigned NumWords    = 1024,
    parameter int unsigned RspDepth    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_type_i,
    input  logic [MemTidWidth-1:0]   req_tid_i,
    input  logic [AddrWidth-1:0]     req_addr_i,
    input  logic [DataWidth-1:0]     req_wdata_i,
    input  logic [DataWidth/8-1:0]   req_be_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [1:0]               rsp_type_o,
    output logic [MemTidWidth-1:0]   rsp_tid_o,
    output logic [LineWidth-1:0]     rsp_data_o,
    output logic                     rsp_err_o
);

    localparam int unsigned ByteLanes = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(ByteLanes);
    localparam int unsigned IdxW      = $clog2(NumWords);
    localparam int unsigned Beats     = LineWidth / DataWidth;
    localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned PtrW      = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CntW      = $clog2(RspDepth + 1);
    localparam logic [AddrWidth:0] AddrLimit = (AddrWidth + 1)'(NumWords * ByteLanes);

    typedef enum logic [1:0] {
        REQ_LOAD  = 2'd0,
        REQ_LINE  = 2'd1,
        REQ_STORE = 2'd2,
        REQ_RSVD  = 2'd3
    } req_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        PUSH   = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]             typ;
        logic [MemTidWidth-1:0] tid;
        logic [LineWidth-1:0]   data;
        logic                   err;
    } rsp_t;

    state_e                 state_q;
    req_type_e              type_q;
    logic [MemTidWidth-1:0] tid_q;
    logic [IdxW-1:0]        idx_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [ByteLanes-1:0]   be_q;
    logic                   err_q;
    logic [BeatW-1:0]       beat_q;
    logic [LineWidth-1:0]   line_q;

    logic [DataWidth-1:0]   mem_q [NumWords];
    rsp_t                   fifo_q [RspDepth];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        cnt_q;

    logic                   req_accept, addr_err, store_en, push, pop;
    logic [IdxW-1:0]        access_idx;
    logic [DataWidth-1:0]   rd_word;
    rsp_t                   push_entry, head;

    // Gated by reset so the port never advertises readiness while reset is held.
    assign req_ready_o = rst_ni && (state_q == IDLE) && (cnt_q < CntW'(RspDepth));
    assign req_accept  = req_valid_i && req_ready_o;
    assign addr_err    = {1'b0, req_addr_i} >= AddrLimit;

    // Line loads walk the beats of the line containing the latched word.
    assign access_idx = (type_q == REQ_LINE)
                      ? ((idx_q & ~IdxW'(Beats - 1)) | IdxW'(beat_q))
                      : idx_q;
    assign rd_word    = mem_q[access_idx];
    assign store_en   = (state_q == ACCESS) && (type_q == REQ_STORE) && !err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            type_q  <= REQ_LOAD;
            tid_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            line_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_accept) begin
                        type_q  <= req_type_e'(req_type_i);
                        tid_q   <= req_tid_i;
                        idx_q   <= req_addr_i[OffW +: IdxW];
                        wdata_q <= req_wdata_i;
                        be_q    <= req_be_i;
                        err_q   <= addr_err || (req_type_i == REQ_RSVD);
                        beat_q  <= '0;
                        line_q  <= '0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (err_q || type_q == REQ_STORE) begin
                        state_q <= PUSH;
                    end else if (type_q == REQ_LINE) begin
                        for (int k = 0; k < Beats; k++) begin
                            if (beat_q == BeatW'(k)) line_q[k*DataWidth +: DataWidth] <= rd_word;
                        end
                        if (beat_q == BeatW'(Beats - 1)) state_q <= PUSH;
                        else                             beat_q  <= beat_q + 1'b1;
                    end else begin
                        line_q[DataWidth-1:0] <= rd_word;
                        state_q               <= PUSH;
                    end
                end
                PUSH:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; only control state needs a known value.
    always_ff @(posedge clk_i) begin
        if (store_en) begin
            for (int b = 0; b < ByteLanes; b++) begin
                if (be_q[b]) mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push = (state_q == PUSH);
    assign pop  = rsp_valid_o && rsp_ready_i;

    assign push_entry.typ  = type_q;
    assign push_entry.tid  = tid_q;
    assign push_entry.data = line_q;
    assign push_entry.err  = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    // Outputs read as zero whenever the FIFO is empty, including under reset.
    assign rsp_valid_o = (cnt_q != '0);
    assign head        = rsp_valid_o ? fifo_q[rd_ptr_q] : '0;
    assign rsp_type_o  = head.typ;
    assign rsp_tid_o   = head.tid;
    assign rsp_data_o  = head.data;
    assign rsp_err_o   = head.err;

endmodule

// File: tb/tb_cva6_wt_mem_responder.sv
// Directed bench for cva6_wt_mem_responder: stores, word/line loads, partial
// byte enables, FIFO back-pressure, error responses and mid-request reset.
module tb_cva6_wt_mem_responder;

    localparam int TW = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 128;

    localparam logic [1:0] T_LOAD  = 2'd0;
    localparam logic [1:0] T_LINE  = 2'd1;
    localparam logic [1:0] T_STORE = 2'd2;
    localparam logic [1:0] T_RSVD  = 2'd3;

    localparam logic [DW-1:0] D26 = 64'h1122334455667788;
    localparam logic [DW-1:0] D27 = 64'h12340000BBBBBBBB;
    localparam logic [DW-1:0] WA  = 64'hA0A1A2A3A4A5A6A7;
    localparam logic [DW-1:0] WB  = 64'hB0B1B2B3B4B5B6B7;
    localparam logic [DW-1:0] WC  = 64'hC0FFEE0012345678;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [1:0]      req_type_i = '0;
    logic [TW-1:0]   req_tid_i = '0;
    logic [AW-1:0]   req_addr_i = '0;
    logic [DW-1:0]   req_wdata_i = '0;
    logic [DW/8-1:0] req_be_i = '0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic [1:0]      rsp_type_o;
    logic [TW-1:0]   rsp_tid_o;
    logic [LW-1:0]   rsp_data_o;
    logic            rsp_err_o;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    always #5 clk_i = ~clk_i;

    cva6_wt_mem_responder #(
        .MemTidWidth(TW), .AddrWidth(AW), .DataWidth(DW),
        .LineWidth(LW), .NumWords(1024), .RspDepth(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_type_i(req_type_i), .req_tid_i(req_tid_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_type_o(rsp_type_o), .rsp_tid_o(rsp_tid_o),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a request at a falling edge and returns just after the accepting rising edge.
    task automatic issue(input logic [1:0] typ, input logic [TW-1:0] tid, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW/8-1:0] be);
        int waits = 0;
        @(negedge clk_i);
        req_type_i  = typ;
        req_tid_i   = tid;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        req_valid_i = 1'b1;
        while (!req_ready_o && waits < 50) begin
            @(negedge clk_i);
            waits++;
        end
        if (!req_ready_o) begin
            check("accept timeout", req_ready_o, 1'b1);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic pop_rsp(input string tag, input logic [1:0] typ, input logic [TW-1:0] tid,
                           input logic [LW-1:0] data, input logic err);
        int waits = 0;
        @(negedge clk_i);
        while (!rsp_valid_o && waits < 50) begin
            @(negedge clk_i);
            waits++;
        end
        if (!rsp_valid_o) begin
            check({tag, " rsp timeout"}, rsp_valid_o, 1'b1);
            return;
        end
        check({tag, " type"}, rsp_type_o, typ);
        check({tag, " tid"},  rsp_tid_o,  tid);
        check({tag, " data"}, rsp_data_o, data);
        check({tag, " err"},  rsp_err_o,  err);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;
    endtask

    // Called right after acceptance: counts falling edges until valid shows.
    // A response in cycle t+3 yields 2, one in t+4 yields 3.
    task automatic measure_latency(output int n);
        n = 0;
        @(negedge clk_i);
        while (!rsp_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst ready", req_ready_o, 1'b0);
        check("rst valid", rsp_valid_o, 1'b0);
        check("rst type",  rsp_type_o,  2'd0);
        check("rst tid",   rsp_tid_o,   '0);
        check("rst data",  rsp_data_o,  '0);
        check("rst err",   rsp_err_o,   1'b0);
        rst_ni = 1'b1;
        #1 check("ready after rst", req_ready_o, 1'b1);

        // Full store then word load of the same word, with latency.
        issue(T_STORE, 2'd1, 32'h10, D26, 8'hFF);
        measure_latency(lat);
        check("store latency", lat, 2);
        pop_rsp("st26", T_STORE, 2'd1, '0, 1'b0);
        issue(T_LOAD, 2'd2, 32'h10, '0, '0);
        measure_latency(lat);
        check("load latency", lat, 2);
        pop_rsp("ld26", T_LOAD, 2'd2, {64'h0, D26}, 1'b0);

        // Partial byte enables on a zeroed word.
        issue(T_STORE, 2'd0, 32'h20, '0, 8'hFF);
        pop_rsp("clr27", T_STORE, 2'd0, '0, 1'b0);
        issue(T_STORE, 2'd3, 32'h20, 64'hAAAAAAAABBBBBBBB, 8'h0F);
        pop_rsp("st27lo", T_STORE, 2'd3, '0, 1'b0);
        issue(T_LOAD, 2'd1, 32'h20, '0, '0);
        pop_rsp("ld27lo", T_LOAD, 2'd1, {64'h0, 64'h00000000BBBBBBBB}, 1'b0);
        issue(T_STORE, 2'd2, 32'h20, 64'h123456789ABCDEF0, 8'hC0);
        pop_rsp("st27hi", T_STORE, 2'd2, '0, 1'b0);
        issue(T_LOAD, 2'd3, 32'h20, '0, '0);
        pop_rsp("ld27hi", T_LOAD, 2'd3, {64'h0, D27}, 1'b0);

        // Line load from an unaligned address inside the line of words 2..3.
        issue(T_STORE, 2'd0, 32'h10, WA, 8'hFF);
        pop_rsp("stA", T_STORE, 2'd0, '0, 1'b0);
        issue(T_STORE, 2'd1, 32'h18, WB, 8'hFF);
        pop_rsp("stB", T_STORE, 2'd1, '0, 1'b0);
        issue(T_LINE, 2'd2, 32'h18, '0, '0);
        measure_latency(lat);
        check("line latency", lat, 3);
        pop_rsp("line18", T_LINE, 2'd2, {WB, WA}, 1'b0);
        issue(T_LINE, 2'd3, 32'h10, '0, '0);
        pop_rsp("line10", T_LINE, 2'd3, {WB, WA}, 1'b0);

        // Back-pressure: four loads fill the FIFO, the fifth waits for a pop.
        issue(T_LOAD, 2'd1, 32'h10, '0, '0);
        issue(T_LOAD, 2'd2, 32'h18, '0, '0);
        issue(T_LOAD, 2'd3, 32'h20, '0, '0);
        issue(T_LOAD, 2'd0, 32'h10, '0, '0);
        repeat (3) @(negedge clk_i);
        req_type_i  = T_LOAD;
        req_tid_i   = 2'd1;
        req_addr_i  = 32'h18;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        check("full ready", req_ready_o, 1'b0);
        @(negedge clk_i);
        check("full ready hold", req_ready_o, 1'b0);
        check("hold tid",  rsp_tid_o,  2'd1);
        check("hold data", rsp_data_o, {64'h0, WA});
        req_valid_i = 1'b0;
        pop_rsp("bp0", T_LOAD, 2'd1, {64'h0, WA}, 1'b0);
        @(negedge clk_i);
        check("ready after pop", req_ready_o, 1'b1);
        issue(T_LOAD, 2'd1, 32'h18, '0, '0);
        pop_rsp("bp1", T_LOAD, 2'd2, {64'h0, WB},  1'b0);
        pop_rsp("bp2", T_LOAD, 2'd3, {64'h0, D27}, 1'b0);
        pop_rsp("bp3", T_LOAD, 2'd0, {64'h0, WA},  1'b0);
        pop_rsp("bp4", T_LOAD, 2'd1, {64'h0, WB},  1'b0);

        // Address range boundaries and reserved type.
        issue(T_STORE, 2'd2, 32'h1FF8, WC, 8'hFF);
        pop_rsp("st last", T_STORE, 2'd2, '0, 1'b0);
        issue(T_LOAD, 2'd3, 32'h1FF8, '0, '0);
        pop_rsp("ld last", T_LOAD, 2'd3, {64'h0, WC}, 1'b0);
        issue(T_LOAD, 2'd2, 32'h2000, '0, '0);
        pop_rsp("ld oor", T_LOAD, 2'd2, '0, 1'b1);
        issue(T_STORE, 2'd1, 32'h2010, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        pop_rsp("st oor", T_STORE, 2'd1, '0, 1'b1);
        issue(T_LOAD, 2'd0, 32'h10, '0, '0);
        pop_rsp("no alias", T_LOAD, 2'd0, {64'h0, WA}, 1'b0);
        issue(T_RSVD, 2'd3, 32'h10, '0, '0);
        measure_latency(lat);
        check("rsvd latency", lat, 2);
        pop_rsp("rsvd", T_RSVD, 2'd3, '0, 1'b1);

        // Reset while a line load is in ACCESS.
        issue(T_LINE, 2'd2, 32'h10, '0, '0);
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst valid", rsp_valid_o, 1'b0);
        check("midrst ready", req_ready_o, 1'b0);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        check("post rst empty", rsp_valid_o, 1'b0);
        check("post rst ready", req_ready_o, 1'b1);
        issue(T_LOAD, 2'd3, 32'h18, '0, '0);
        pop_rsp("post rst ld", T_LOAD, 2'd3, {64'h0, WB}, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
